// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller (master) takes the opcode, the ALU zero flag and the memory
// ready flag, and drives every datapath control strobe plus its debug state.
//
// Handshake: mem_read / mem_write act as the request ("valid") and are held
// steady until memory answers. mem_ready is the memory's "ready": the access
// completes on the clock edge where the request and mem_ready are both high.
// The controller never withdraws a request before that edge, except under
// reset.
interface multicycle_control_if #(
    parameter int OPW = 6,
    parameter int SW  = 4
);
    // datapath -> controller
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;

    // controller -> datapath
    logic           pc_write;
    logic           branch;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_src;
    logic           illegal;
    logic [SW-1:0]  state;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal, state
    );

    // Datapath side
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor.
// Walks fetch / decode / execute / memory / writeback for lw, sw, R-type,
// beq, addi and j. Outputs are decoded from the state register alone, except
// for three terms: the fetch-cycle PC/IR load waits for mem_ready, it is
// held off while rst_n is low, and the DECODE illegal flag looks at the
// opcode.
module multicycle_control #(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [SW-1:0] {
        FETCH  = SW'(0),
        DECODE = SW'(1),
        MEMADR = SW'(2),
        MEMRD  = SW'(3),
        MEMWB  = SW'(4),
        MEMWR  = SW'(5),
        EXEC   = SW'(6),
        ALUWB  = SW'(7),
        BEQ    = SW'(8),
        ADDIEX = SW'(9),
        ADDIWB = SW'(10),
        JUMP   = SW'(11)
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    state_t cur_state;

    // State register: reset goes straight to FETCH, which drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (bus.mem_ready) cur_state <= DECODE;
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: cur_state <= MEMADR;
                        OP_RTYPE:     cur_state <= EXEC;
                        OP_BEQ:       cur_state <= BEQ;
                        OP_ADDI:      cur_state <= ADDIEX;
                        OP_J:         cur_state <= JUMP;
                        default:      cur_state <= FETCH;
                    endcase
                end
                // The IR still holds the opcode, so lw and sw split here.
                MEMADR: cur_state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (bus.mem_ready) cur_state <= MEMWB;
                end
                MEMWB:  cur_state <= FETCH;
                MEMWR: begin
                    if (bus.mem_ready) cur_state <= FETCH;
                end
                EXEC:   cur_state <= ALUWB;
                ALUWB:  cur_state <= FETCH;
                BEQ:    cur_state <= FETCH;
                ADDIEX: cur_state <= ADDIWB;
                ADDIWB: cur_state <= FETCH;
                JUMP:   cur_state <= FETCH;
                // Unused codes 12-15 recover to FETCH.
                default: cur_state <= FETCH;
            endcase
        end
    end

    // Control decode from the current state; all strobes default low.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        bus.illegal    = 1'b0;
        case (cur_state)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // PC+4 and IR load only on the completing cycle, never in reset.
                bus.pc_write  = bus.mem_ready & rst_n;
                bus.ir_write  = bus.mem_ready & rst_n;
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut here.
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J:
                        bus.illegal = 1'b0;
                    default:
                        bus.illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
            end
            MEMWB: begin
                bus.reg_dst    = 1'b0;
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            MEMWR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.branch    = 1'b1;
                bus.pc_src    = 2'b01;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                bus.reg_dst   = 1'b0;
                bus.reg_write = 1'b1;
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            default: begin
                bus.pc_write = 1'b0;
            end
        endcase
    end

    // Debug view of the state register.
    assign bus.state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions, a mid-instruction
// reset, then a random instruction stream with random memory wait states.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Expected per-cycle steps: {state[3:0], mem_ready to drive, illegal}
    logic [5:0] exp_q[$];

    multicycle_control_if #(.OPW(6), .SW(4)) bus ();

    multicycle_control #(.OPW(6), .SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Instruction classes: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 addi, 6 j
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b000100: return 4;
            6'b001000: return 5;
            6'b000010: return 6;
            default:   return 0;
        endcase
    endfunction

    // Observed control word, packed in a fixed order.
    function automatic logic [16:0] dut_ctrl();
        return {bus.pc_write, bus.branch, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal};
    endfunction

    // Control word the specification's state table calls for.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic ill);
        logic pw, br, iod, mr, mw, irw, rd, m2r, rw, sa, il;
        logic [1:0] sb, op, ps;
        pw = 0; br = 0; iod = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0;
        rw = 0; sa = 0; il = 0; sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
            4'd1:  begin sb = 2'b11; il = ill; end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin iod = 1; mr = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iod = 1; mw = 1; end
            4'd6:  begin sa = 1; op = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; op = 2'b01; br = 1; ps = 2'b01; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin pw = 1; ps = 2'b10; end
            default: begin end
        endcase
        return {pw, br, iod, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, il};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- driver ----------------
    // Entered just after a posedge with the DUT in FETCH. wf = fetch wait
    // cycles, wm = data memory wait cycles (lw/sw only).
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int cls;
        int rw_n;
        int mw_n;
        logic [5:0] step;
        cls  = op_class(op);
        rw_n = 0;
        mw_n = 0;
        exp_q = {};
        for (int i = 0; i < wf; i++) exp_q.push_back({4'd0, 1'b0, 1'b0});
        exp_q.push_back({4'd0, 1'b1, 1'b0});
        exp_q.push_back({4'd1, rnd_bit(), 1'(cls == 0)});
        case (cls)
            1: begin
                exp_q.push_back({4'd2, rnd_bit(), 1'b0});
                for (int i = 0; i < wm; i++) exp_q.push_back({4'd3, 1'b0, 1'b0});
                exp_q.push_back({4'd3, 1'b1, 1'b0});
                exp_q.push_back({4'd4, rnd_bit(), 1'b0});
            end
            2: begin
                exp_q.push_back({4'd2, rnd_bit(), 1'b0});
                for (int i = 0; i < wm; i++) exp_q.push_back({4'd5, 1'b0, 1'b0});
                exp_q.push_back({4'd5, 1'b1, 1'b0});
            end
            3: begin
                exp_q.push_back({4'd6, rnd_bit(), 1'b0});
                exp_q.push_back({4'd7, rnd_bit(), 1'b0});
            end
            4: exp_q.push_back({4'd8, rnd_bit(), 1'b0});
            5: begin
                exp_q.push_back({4'd9, rnd_bit(), 1'b0});
                exp_q.push_back({4'd10, rnd_bit(), 1'b0});
            end
            6: exp_q.push_back({4'd11, rnd_bit(), 1'b0});
            default: begin end
        endcase

        bus.opcode = op;
        while (exp_q.size() > 0) begin
            step = exp_q.pop_front();
            bus.mem_ready = step[1];
            bus.zero      = rnd_bit();
            @(negedge clk);
            check_eq("state", 32'(bus.state), 32'(step[5:2]));
            check_eq("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(step[5:2], step[1], step[0])));
            if (bus.reg_write) rw_n++;
            if (bus.mem_write) mw_n++;
            @(posedge clk);
            #1;
        end
        check_eq("reg_write_cnt", rw_n, (cls == 1 || cls == 3 || cls == 5) ? 1 : 0);
        check_eq("mem_write_cnt", mw_n, (cls == 2) ? wm + 1 : 0);
    endtask

    // Reset asserted while sw waits in MEMWR.
    task automatic reset_in_memwr();
        bus.opcode    = 6'b101011;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;   // DECODE
        @(posedge clk); #1;   // MEMADR
        @(posedge clk); #1;   // MEMWR
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_state", 32'(bus.state), 32'd5);
        check_eq("rst_pre_mem_write", 32'(bus.mem_write), 32'd1);
        #2;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_state", 32'(bus.state), 32'd0);
        check_eq("rst_async_mem_write", 32'(bus.mem_write), 32'd0);
        check_eq("rst_async_pc_write", 32'(bus.pc_write), 32'd0);
        check_eq("rst_async_ir_write", 32'(bus.ir_write), 32'd0);
        check_eq("rst_async_mem_read", 32'(bus.mem_read), 32'd1);
        @(posedge clk); #1;
        check_eq("rst_hold_state", 32'(bus.state), 32'd0);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_release_state", 32'(bus.state), 32'd0);
        check_eq("rst_release_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(4'd0, 1'b0, 1'b0)));
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] legal_ops [7];
        logic [5:0] op;
        int pick;
        legal_ops[0] = 6'b100011;
        legal_ops[1] = 6'b101011;
        legal_ops[2] = 6'b000000;
        legal_ops[3] = 6'b000100;
        legal_ops[4] = 6'b001000;
        legal_ops[5] = 6'b000010;
        legal_ops[6] = 6'b111111;

        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        #3;
        check_eq("reset_state", 32'(bus.state), 32'd0);
        check_eq("reset_pc_write", 32'(bus.pc_write), 32'd0);
        check_eq("reset_ir_write", 32'(bus.ir_write), 32'd0);
        check_eq("reset_mem_read", 32'(bus.mem_read), 32'd1);
        check_eq("reset_alu_src_b", 32'(bus.alu_src_b), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed instructions
        run_instr(6'b100011, 0, 0);   // lw: 0,1,2,3,4
        run_instr(6'b000000, 0, 0);   // R-type: 0,1,6,7
        run_instr(6'b101011, 0, 3);   // sw with 3 wait cycles in MEMWR
        run_instr(6'b000100, 0, 0);   // beq
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b111111, 0, 0);   // illegal opcode
        run_instr(6'b001000, 2, 0);   // addi with fetch waits
        run_instr(6'b100011, 1, 2);   // lw with fetch and read waits

        reset_in_memwr();

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            if (pick < 7) op = legal_ops[pick];
            else          op = 6'($urandom_range(0, 63));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
